// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks the EX/MEM producers, registers the EX operand forward select and raises the load-use stall.
// Forward select appears 1 cycle after ID presentation; stall is combinational and holds ID for exactly one cycle.
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [3:0]       redirection_ctrl,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } rec_t;

  rec_t ex_rec;
  rec_t mem_rec;
  rec_t id_rec;

  logic       a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;
  logic       a_alu, a_mem, b_alu, b_mem;
  logic       advance;
  logic [3:0] ctrl_nxt;

  // Register 0 is hardwired to zero, so a write to it can never be a producer.
  function automatic logic hits(input rec_t r, input logic [REG_W-1:0] idx);
    return r.valid & r.wr_en & (r.dst == idx) & (idx != '0);
  endfunction

  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.wr_en   = id_wr_en;
    id_rec.dst     = id_wr_reg;
    id_rec.is_load = id_is_load;

    a_ex_hit  = id_rs_used & hits(ex_rec, id_rs);
    a_mem_hit = id_rs_used & hits(mem_rec, id_rs);
    b_ex_hit  = id_rt_used & hits(ex_rec, id_rt);
    b_mem_hit = id_rt_used & hits(mem_rec, id_rt);

    // A flush kills the consumer, so a coincident load-use never stalls.
    stall   = ~flush & id_valid & ex_rec.is_load & (a_ex_hit | b_ex_hit);
    advance = id_valid & ~stall & ~flush;

    // The younger producer in EX takes priority over the older one in MEM.
    a_alu = a_ex_hit & ~ex_rec.is_load;
    a_mem = ~a_alu & a_mem_hit;
    b_alu = b_ex_hit & ~ex_rec.is_load;
    b_mem = ~b_alu & b_mem_hit;

    ctrl_nxt = advance ? {b_mem, b_alu, a_mem, a_alu} : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rec           <= '0;
      mem_rec          <= '0;
      redirection_ctrl <= 4'b0000;
      stall_count      <= '0;
    end else begin
      mem_rec          <= ex_rec;
      ex_rec           <= advance ? id_rec : '0;
      redirection_ctrl <= ctrl_nxt;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed MIPS hazard sequences followed by random instruction streams, checked against a producer-history model.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic [3:0]  ctrl, ctrl_s;
  logic        stall, stall_s;
  logic [31:0] cnt;
  logic [2:0]  cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .redirection_ctrl(ctrl), .stall(stall), .stall_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  hazard_forward_ctrl #(.REG_W(5), .CNT_W(3)) u_dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .redirection_ctrl(ctrl_s), .stall(stall_s), .stall_count(cnt_s)
  );

  // Model: history of what entered EX, newest first (slot 0 = now in EX, slot 1 = now in MEM).
  typedef struct {
    logic       v;
    logic       wr;
    logic [4:0] dst;
    logic       ld;
  } ins_t;

  ins_t        hist[$];
  ins_t        bubble = '{v: 1'b0, wr: 1'b0, dst: 5'd0, ld: 1'b0};
  logic [3:0]  exp_ctrl;
  logic [31:0] exp_cnt;
  logic [2:0]  exp_cnt_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Age of the most recent in-flight writer of r, or -1 if none.
  function automatic int writer(input logic [4:0] r);
    for (int i = 0; i < 2; i++) begin
      if (r != 5'd0 && hist[i].v && hist[i].wr && hist[i].dst == r) return i;
    end
    return -1;
  endfunction

  // {mem_out, alu_out} select for one operand.
  function automatic logic [1:0] sel(input logic used, input logic [4:0] r);
    int w;
    w = writer(r);
    if (!used || w < 0) return 2'b00;
    if (w == 0) return hist[0].ld ? 2'b00 : 2'b01;
    return 2'b10;
  endfunction

  task automatic model_reset();
    hist      = {bubble, bubble};
    exp_ctrl  = 4'd0;
    exp_cnt   = 32'd0;
    exp_cnt_s = 3'd0;
  endtask

  task automatic cycle(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic wr,
                       input logic [4:0] wd, input logic ld, input logic fl,
                       output logic st);
    logic       exp_stall, adv;
    logic [3:0] nxt_ctrl;
    ins_t       nw;
    @(negedge clk);
    id_valid = v;   id_rs = rs;        id_rt = rt;
    id_rs_used = rsu; id_rt_used = rtu; id_wr_en = wr;
    id_wr_reg = wd; id_is_load = ld;   flush = fl;
    #1;
    exp_stall = !fl && v && hist[0].ld &&
                ((rsu && writer(rs) == 0) || (rtu && writer(rt) == 0));
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("stall_small", {31'd0, stall_s}, {31'd0, exp_stall});
    adv      = v && !exp_stall && !fl;
    nxt_ctrl = adv ? {sel(rtu, rt), sel(rsu, rs)} : 4'd0;
    nw       = adv ? '{v: 1'b1, wr: wr, dst: wd, ld: ld} : bubble;
    if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    if (exp_stall && exp_cnt_s != 3'd7) exp_cnt_s = exp_cnt_s + 3'd1;
    @(posedge clk);
    #1;
    hist     = {nw, hist[0]};
    exp_ctrl = nxt_ctrl;
    chk("ctrl", {28'd0, ctrl}, {28'd0, exp_ctrl});
    chk("ctrl_small", {28'd0, ctrl_s}, {28'd0, exp_ctrl});
    chk("stall_count", cnt, exp_cnt);
    chk("stall_count_sat", {29'd0, cnt_s}, {29'd0, exp_cnt_s});
    st = exp_stall;
  endtask

  // Present one instruction and hold it in ID while the pipeline stalls it.
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic wr,
                       input logic [4:0] wd, input logic ld, input logic fl);
    logic st;
    int   n;
    n = 0;
    cycle(v, rs, rt, rsu, rtu, wr, wd, ld, fl, st);
    while (st && n < 3) begin
      n++;
      cycle(v, rs, rt, rsu, rtu, wr, wd, ld, 1'b0, st);
    end
    chk("stall_bound", {31'd0, st}, 32'd0);
  endtask

  initial begin
    logic        st;
    logic [31:0] c0;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; flush = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_ctrl", {28'd0, ctrl}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_count", cnt, 32'd0);
    rst = 1'b0;

    // ALU-ALU: add $3,$1,$2 ; sub $4,$3,$5
    issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
    issue(1, 5'd3, 5'd5, 1, 1, 1, 5'd4, 0, 0);
    chk("t1_alu_alu", {28'd0, ctrl}, 32'b0001);

    // Distance 2: add $3 ; nop ; or $6,$7,$3
    issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
    issue(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    issue(1, 5'd7, 5'd3, 1, 1, 1, 5'd6, 0, 0);
    chk("t2_dist2", {28'd0, ctrl}, 32'b1000);

    // Double producer: add $3 ; add $3 ; use $3 on both operands
    issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);
    issue(1, 5'd4, 5'd2, 1, 1, 1, 5'd3, 0, 0);
    issue(1, 5'd3, 5'd3, 1, 1, 1, 5'd10, 0, 0);
    chk("t3_younger_wins", {28'd0, ctrl}, 32'b0101);

    // Load-use: lw $8 ; add $9,$8,$8
    issue(1, 5'd1, 5'd0, 1, 0, 1, 5'd8, 1, 0);
    c0 = cnt;
    cycle(1, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 0, st);
    chk("t4_bubble_ctrl", {28'd0, ctrl}, 32'd0);
    chk("t4_count_inc", cnt, c0 + 32'd1);
    cycle(1, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 0, st);
    chk("t4_mem_fwd", {28'd0, ctrl}, 32'b1010);
    chk("t4_one_stall", cnt, c0 + 32'd1);

    // Register 0: add $0 ; use $0
    issue(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0);
    issue(1, 5'd0, 5'd0, 1, 1, 1, 5'd5, 0, 0);
    chk("t5_reg0", {28'd0, ctrl}, 32'd0);

    // Flush coincident with load-use
    issue(1, 5'd1, 5'd0, 1, 0, 1, 5'd8, 1, 0);
    c0 = cnt;
    cycle(1, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 1, st);
    chk("t6_flush_ctrl", {28'd0, ctrl}, 32'd0);
    chk("t6_flush_count", cnt, c0);

    // Async reset in the middle of a stall
    issue(1, 5'd1, 5'd0, 1, 0, 1, 5'd8, 1, 0);
    @(negedge clk);
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd8; id_rs_used = 1; id_rt_used = 1;
    id_wr_en = 1; id_wr_reg = 5'd9; id_is_load = 0; flush = 0;
    #1;
    chk("t6_stall_before_rst", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'd0, stall}, 32'd0);
    chk("t6_rst_ctrl", {28'd0, ctrl}, 32'd0);
    chk("t6_rst_count", cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random instruction streams over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
